step_ramp: RTL and testbench
============================

STEP_RAMP -- requirements
Module: step_ramp

Interface
REQ-001 The module SHALL have parameter PERIOD_WIDTH, default 24, which sets the bit width of all step-period values in clock cycles.
REQ-002 The module SHALL have parameter PULSE_WIDTH, default 25, which sets the step high time in cycles (1 us at 25 MHz).
REQ-003 The module SHALL have port clk_in, input, width 1: the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port reset_in, input, width 1: reset, asynchronous and active-high.
REQ-005 The module SHALL have port start_in, input, width 1: move request, sampled each cycle.
REQ-006 The module SHALL have port abort_in, input, width 1: immediate stop request.
REQ-007 The module SHALL have port steps_in, input, width 32: number of steps in the move.
REQ-008 The module SHALL have port dir_in, input, width 1: requested direction.
REQ-009 The module SHALL have port period_start_in, input, width PERIOD_WIDTH: start and stop step period in cycles.
REQ-010 The module SHALL have port period_min_in, input, width PERIOD_WIDTH: cruise step period in cycles.
REQ-011 The module SHALL have port accel_in, input, width PERIOD_WIDTH: period change applied per step.
REQ-012 The module SHALL have port step_out, output, width 1: step pulse to the motor driver.
REQ-013 The module SHALL have port dir_out, output, width 1: latched direction.
REQ-014 The module SHALL have port busy_out, output, width 1: a move is in progress.
REQ-015 The module SHALL have port done_out, output, width 1: one-cycle pulse when a move completes normally.
REQ-016 The module SHALL have port steps_left_out, output, width 32: steps not yet issued.

Function
REQ-017 States SHALL be IDLE, SETUP, ACCEL, CRUISE and DECEL.
REQ-018 In IDLE, start_in=1 SHALL be accepted; start_in SHALL be ignored in every other state.
REQ-019 On acceptance, the module SHALL latch steps_in, dir_in, period_start_in, period_min_in and accel_in, and update dir_out on the acceptance edge.
REQ-020 Latched periods below 2*PULSE_WIDTH SHALL be clamped to 2*PULSE_WIDTH, and a latched period_min greater than period_start SHALL be clamped to period_start.
REQ-021 If accepted with steps_in=0, the module SHALL return to IDLE with done_out=1 for one cycle on the next edge, keep busy_out at 0, and issue no step.
REQ-022 Otherwise, the module SHALL enter SETUP with busy_out=1 from the acceptance edge, and the first step_out rising edge SHALL occur PULSE_WIDTH cycles after acceptance (direction setup time).
REQ-023 Each step SHALL hold step_out=1 for exactly PULSE_WIDTH cycles, and the next rising edge SHALL occur exactly current-period cycles after the previous rising edge.
REQ-024 The first step SHALL use period_start, the state SHALL be ACCEL, and the accel-count SHALL be 0.
REQ-025 steps_left_out SHALL decrement by 1 on each step rising edge.
REQ-026 At each step rising edge with remaining steps r after the decrement, if r <= accel-count the state SHALL become DECEL.
REQ-027 Otherwise in ACCEL, if period - accel > period_min then period SHALL decrease by accel and accel-count SHALL increment; else period SHALL become period_min and the state SHALL become CRUISE, with accel-count incremented only if period actually changed.
REQ-028 In DECEL, period SHALL increase by accel per step, saturating at period_start, and accel-count SHALL decrement, saturating at 0.
REQ-029 accel_in=0 SHALL give a constant period_start move that never leaves ACCEL until the final-step check.
REQ-030 When r=0, after the last step's full period elapses the module SHALL return to IDLE, busy_out SHALL fall, and done_out SHALL be 1 for that same single cycle.
REQ-031 Period arithmetic SHALL be PERIOD_WIDTH+1 bits internally, with no wrap on underflow or overflow.
REQ-032 abort_in=1 in any non-IDLE state SHALL give IDLE on the next edge with step_out=0, busy_out=0, done_out=0 and steps_left_out held at its current value.
REQ-033 abort_in SHALL take priority over a step edge in the same cycle, and abort_in in IDLE SHALL take priority over start_in.
REQ-034 dir_out SHALL change only on acceptance.

Reset
REQ-035 reset_in=1 SHALL asynchronously force IDLE, step_out=0, dir_out=0, busy_out=0, done_out=0, steps_left_out=0, and clear all latched values and accel-count.
REQ-036 Reset asserted mid-pulse SHALL drop step_out immediately, with no partial move resumed after release.
REQ-037 The first start_in SHALL be accepted on the first rising edge after reset_in deasserts.

Verification
REQ-038 Scenario 1: steps=4, period_start=period_min=100, accel=0 -> 4 pulses 25 cycles high, rising edges 100 apart, first rising edge 25 cycles after start, done_out 100 cycles after the 4th rising edge.
REQ-039 Scenario 2: steps=10, start=1000, min=700, accel=100 -> periods 1000,900,800,700,700,700,700,800,900,1000 with states ACCEL, CRUISE, DECEL.
REQ-040 Scenario 3: steps=3, start=1000, min=100, accel=100 -> periods 1000,900,1000 (triangle, no CRUISE).
REQ-041 Scenario 4: steps=0 -> done_out one cycle after start, busy_out stays 0, no step_out.
REQ-042 Scenario 5: abort_in during step 3 high phase of a 10-step move -> step_out=0 and busy_out=0 next cycle, steps_left_out=7, no done_out, start_in re-accepted after.
REQ-043 Scenario 6: period_start=10 with PULSE_WIDTH=25 -> clamped period 50; start_in pulsed while busy -> ignored; reset_in mid-move -> all outputs 0 immediately.

Source files
------------

// File: rtl/step_ramp.sv
// Trapezoidal step/direction pulse generator: accelerates from a start period to a
// cruise period, then decelerates so the final step runs at the start period again.
module step_ramp #(
    parameter int PERIOD_WIDTH = 24,
    parameter int PULSE_WIDTH  = 25
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic [31:0]             steps_in,
    input  logic                    dir_in,
    input  logic [PERIOD_WIDTH-1:0] period_start_in,
    input  logic [PERIOD_WIDTH-1:0] period_min_in,
    input  logic [PERIOD_WIDTH-1:0] accel_in,
    output logic                    step_out,
    output logic                    dir_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [31:0]             steps_left_out
);

    localparam int PW = PERIOD_WIDTH;
    localparam int EW = PERIOD_WIDTH + 1;
    localparam logic [PW-1:0] MIN_PERIOD = PW'(2 * PULSE_WIDTH);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_DECEL  = 3'd4
    } state_t;

    state_t        state_r;
    logic [PW-1:0] period_start_r;
    logic [PW-1:0] period_min_r;
    logic [PW-1:0] accel_r;
    logic [PW-1:0] period_r;
    logic [PW-1:0] timer_r;
    logic [PW-1:0] high_cnt_r;
    logic [31:0]   accel_cnt_r;
    logic [31:0]   steps_left_r;
    logic          step_r;
    logic          dir_r;
    logic          busy_r;
    logic          done_r;

    logic [PW-1:0] start_clamp_s;
    logic [PW-1:0] min_floor_s;
    logic [PW-1:0] min_clamp_s;
    logic [31:0]   remain_s;
    state_t        prof_state_s;
    state_t        next_state_s;
    logic [PW-1:0] next_period_s;
    logic [31:0]   next_cnt_s;
    logic [EW-1:0] ext_period_s;
    logic [EW-1:0] decel_sum_s;
    logic [EW-1:0] accel_floor_s;
    logic [EW-1:0] accel_diff_s;

    function automatic logic [PW-1:0] clamp_low(input logic [PW-1:0] p);
        if (p < MIN_PERIOD) begin
            return MIN_PERIOD;
        end else begin
            return p;
        end
    endfunction

    // Periods as they will be latched on acceptance: floor at twice the pulse width, cruise never slower than start
    always_comb begin
        start_clamp_s = clamp_low(period_start_in);
        min_floor_s   = clamp_low(period_min_in);
        if (min_floor_s > start_clamp_s) begin
            min_clamp_s = start_clamp_s;
        end else begin
            min_clamp_s = min_floor_s;
        end
    end

    assign remain_s      = steps_left_r - 32'd1;
    assign prof_state_s  = (state_r == ST_SETUP) ? ST_ACCEL : state_r;
    assign ext_period_s  = {1'b0, period_r};
    assign decel_sum_s   = ext_period_s + {1'b0, accel_r};
    assign accel_floor_s = {1'b0, period_min_r} + {1'b0, accel_r};
    assign accel_diff_s  = ext_period_s - {1'b0, accel_r};

    // Profile update applied at every step rising edge, using the remaining count after that step
    always_comb begin
        next_state_s  = prof_state_s;
        next_period_s = period_r;
        next_cnt_s    = accel_cnt_r;
        if ((remain_s <= accel_cnt_r) || (prof_state_s == ST_DECEL)) begin
            next_state_s = ST_DECEL;
            if (decel_sum_s > {1'b0, period_start_r}) begin
                next_period_s = period_start_r;
            end else begin
                next_period_s = decel_sum_s[PW-1:0];
            end
            if (accel_cnt_r != 32'd0) begin
                next_cnt_s = accel_cnt_r - 32'd1;
            end else begin
                next_cnt_s = 32'd0;
            end
        end else if (prof_state_s == ST_ACCEL) begin
            // Zero acceleration holds the start period and never consumes decel budget
            if (accel_r == {PW{1'b0}}) begin
                next_period_s = period_r;
            end else if (ext_period_s > accel_floor_s) begin
                next_period_s = accel_diff_s[PW-1:0];
                next_cnt_s    = accel_cnt_r + 32'd1;
            end else begin
                next_period_s = period_min_r;
                next_state_s  = ST_CRUISE;
                if (period_r != period_min_r) begin
                    next_cnt_s = accel_cnt_r + 32'd1;
                end else begin
                    next_cnt_s = accel_cnt_r;
                end
            end
        end else begin
            next_period_s = period_r;
        end
    end

    // Move sequencer: acceptance, step timing, pulse width, completion and abort
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r        <= ST_IDLE;
            period_start_r <= {PW{1'b0}};
            period_min_r   <= {PW{1'b0}};
            accel_r        <= {PW{1'b0}};
            period_r       <= {PW{1'b0}};
            timer_r        <= {PW{1'b0}};
            high_cnt_r     <= {PW{1'b0}};
            accel_cnt_r    <= 32'd0;
            steps_left_r   <= 32'd0;
            step_r         <= 1'b0;
            dir_r          <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (abort_in) begin
                        state_r <= ST_IDLE;
                    end else if (start_in) begin
                        dir_r          <= dir_in;
                        period_start_r <= start_clamp_s;
                        period_min_r   <= min_clamp_s;
                        accel_r        <= accel_in;
                        period_r       <= start_clamp_s;
                        accel_cnt_r    <= 32'd0;
                        steps_left_r   <= steps_in;
                        if (steps_in == 32'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r <= ST_SETUP;
                            busy_r  <= 1'b1;
                            timer_r <= PULSE_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP, ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                    if (abort_in) begin
                        state_r <= ST_IDLE;
                        step_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        if (step_r) begin
                            if (high_cnt_r == {PW{1'b0}}) begin
                                step_r <= 1'b0;
                            end else begin
                                high_cnt_r <= high_cnt_r - PW'(1);
                            end
                        end
                        if (timer_r != {PW{1'b0}}) begin
                            timer_r <= timer_r - PW'(1);
                        end else if ((state_r != ST_SETUP) && (steps_left_r == 32'd0)) begin
                            state_r <= ST_IDLE;
                            step_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            step_r       <= 1'b1;
                            high_cnt_r   <= PULSE_LOAD;
                            timer_r      <= period_r - PW'(1);
                            steps_left_r <= remain_s;
                            state_r      <= next_state_s;
                            period_r     <= next_period_s;
                            accel_cnt_r  <= next_cnt_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    step_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign step_out       = step_r;
    assign dir_out        = dir_r;
    assign busy_out       = busy_r;
    assign done_out       = done_r;
    assign steps_left_out = steps_left_r;

endmodule

// File: tb/tb_step_ramp.sv
// Randomized self-checking bench for step_ramp with a step-list reference model.
module tb_step_ramp;

    localparam int PW = 25;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [31:0] steps_in = 32'd0;
    logic        dir_in = 1'b0;
    logic [23:0] period_start_in = 24'd0;
    logic [23:0] period_min_in = 24'd0;
    logic [23:0] accel_in = 24'd0;
    logic        step_out;
    logic        dir_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] steps_left_out;

    int total = 0;
    int bad = 0;

    int rises[$];
    int highs[$];
    int sl_rise[$];
    int exp_q[$];
    int done_t;
    int done_cnt;
    int busy_low;
    int busy_at_done;

    step_ramp #(.PERIOD_WIDTH(24), .PULSE_WIDTH(PW)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
        .steps_in(steps_in), .dir_in(dir_in), .period_start_in(period_start_in),
        .period_min_in(period_min_in), .accel_in(accel_in), .step_out(step_out),
        .dir_out(dir_out), .busy_out(busy_out), .done_out(done_out),
        .steps_left_out(steps_left_out)
    );

    always #20 clk_in = ~clk_in;

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: got no finish, want finish within cycle budget");
        $fatal(1);
    end

    // Per-step period list from the ramp rules, using wide signed arithmetic
    task automatic model_periods(input int n, input int ps_in, input int pm_in, input int acc);
        longint ps, pm, p, cnt;
        int mode;
        ps = (ps_in < 2 * PW) ? 2 * PW : ps_in;
        pm = (pm_in < 2 * PW) ? 2 * PW : pm_in;
        if (pm > ps) pm = ps;
        p = ps; cnt = 0; mode = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            longint r;
            exp_q.push_back(int'(p));
            r = n - 1 - i;
            if (r <= cnt || mode == 2) begin
                mode = 2;
                p = (p + acc > ps) ? ps : p + acc;
                cnt = (cnt > 0) ? cnt - 1 : 0;
            end else if (mode == 0 && acc != 0) begin
                if (p - acc > pm) begin
                    p = p - acc; cnt = cnt + 1;
                end else begin
                    if (p != pm) cnt = cnt + 1;
                    p = pm; mode = 1;
                end
            end
        end
    endtask

    task automatic start_move(input int n, input logic d, input int ps, input int pm, input int acc);
        @(negedge clk_in);
        steps_in = 32'(n); dir_in = d;
        period_start_in = 24'(ps); period_min_in = 24'(pm); accel_in = 24'(acc);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // Records rising-edge offsets (cycles after acceptance), pulse lengths and done timing
    task automatic measure(input int budget, input int poke_t);
        int hl;
        logic prev;
        rises.delete(); highs.delete(); sl_rise.delete();
        done_t = -1; done_cnt = 0; busy_low = 0; busy_at_done = 1; hl = 0; prev = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (t > 0) @(negedge clk_in);
            if (step_out === 1'b1 && prev !== 1'b1) begin
                rises.push_back(t); sl_rise.push_back(int'(steps_left_out)); hl = 0;
            end
            if (step_out === 1'b1) hl++;
            else if (prev === 1'b1) highs.push_back(hl);
            if (done_out === 1'b1) begin
                done_cnt++;
                if (done_t < 0) begin done_t = t; busy_at_done = int'(busy_out); end
            end
            if (done_t < 0 && busy_out !== 1'b1) busy_low++;
            prev = step_out;
            if (t == poke_t) begin steps_in = 32'd99; dir_in = ~dir_in; start_in = 1'b1; end
            if (t == poke_t + 1) start_in = 1'b0;
            if (done_t >= 0 && t >= done_t + 4) break;
        end
    endtask

    task automatic test_reset();
        #5;
        total++; if (step_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || dir_out !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got step=%b busy=%b done=%b dir=%b want all 0", step_out, busy_out, done_out, dir_out);
        end
        total++; if (steps_left_out !== 32'd0) begin
            bad++; $display("FAIL reset_steps_left: got %0d want 0", steps_left_out);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_profile();
        int s1[4] = '{100, 100, 100, 100};
        int s2[10] = '{1000, 900, 800, 700, 700, 700, 700, 800, 900, 1000};
        int s3[3] = '{1000, 900, 1000};
        for (int k = 0; k < 8; k++) begin
            int n, ps, pm, acc, t_exp, sum;
            logic d;
            exp_q.delete();
            case (k)
                0: begin n = 4; ps = 100; pm = 100; acc = 0; foreach (s1[i]) exp_q.push_back(s1[i]); end
                1: begin n = 10; ps = 1000; pm = 700; acc = 100; foreach (s2[i]) exp_q.push_back(s2[i]); end
                2: begin n = 3; ps = 1000; pm = 100; acc = 100; foreach (s3[i]) exp_q.push_back(s3[i]); end
                default: begin
                    n = $urandom_range(1, 10); ps = $urandom_range(30, 300);
                    pm = $urandom_range(20, ps); acc = $urandom_range(0, 60);
                    model_periods(n, ps, pm, acc);
                end
            endcase
            d = 1'($urandom_range(0, 1));
            sum = 0;
            foreach (exp_q[i]) sum += exp_q[i];
            start_move(n, d, ps, pm, acc);
            measure(PW + sum + 20, -1);
            total++; if (rises.size() !== n) begin
                bad++; $display("FAIL move%0d_step_count: got %0d want %0d", k, rises.size(), n);
            end
            t_exp = PW;
            for (int i = 0; i < n && i < rises.size(); i++) begin
                total++; if (rises[i] !== t_exp) begin
                    bad++; $display("FAIL move%0d_rise%0d: got cycle %0d want %0d", k, i, rises[i], t_exp);
                end
                total++; if (sl_rise[i] !== n - 1 - i) begin
                    bad++; $display("FAIL move%0d_steps_left%0d: got %0d want %0d", k, i, sl_rise[i], n - 1 - i);
                end
                t_exp += exp_q[i];
            end
            total++; if (highs.size() !== n) begin
                bad++; $display("FAIL move%0d_pulse_count: got %0d want %0d", k, highs.size(), n);
            end
            foreach (highs[i]) begin
                total++; if (highs[i] !== PW) begin
                    bad++; $display("FAIL move%0d_pulse_width%0d: got %0d want %0d", k, i, highs[i], PW);
                end
            end
            total++; if (done_t !== PW + sum || done_cnt !== 1) begin
                bad++; $display("FAIL move%0d_done: got cycle %0d count %0d want cycle %0d count 1", k, done_t, done_cnt, PW + sum);
            end
            total++; if (busy_low !== 0 || busy_at_done !== 0) begin
                bad++; $display("FAIL move%0d_busy: got low_cycles=%0d at_done=%0d want 0 and 0", k, busy_low, busy_at_done);
            end
            total++; if (dir_out !== d) begin
                bad++; $display("FAIL move%0d_dir: got %b want %b", k, dir_out, d);
            end
        end
    endtask

    task automatic test_zero_steps();
        int steps_seen, busy_seen, done_seen;
        start_move(0, 1'b1, 100, 100, 0);
        total++; if (done_out !== 1'b1 || busy_out !== 1'b0) begin
            bad++; $display("FAIL zero_steps_done: got done=%b busy=%b want done=1 busy=0", done_out, busy_out);
        end
        total++; if (dir_out !== 1'b1) begin
            bad++; $display("FAIL zero_steps_dir: got %b want 1", dir_out);
        end
        steps_seen = 0; busy_seen = 0; done_seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk_in);
            if (step_out === 1'b1) steps_seen++;
            if (busy_out === 1'b1) busy_seen++;
            if (done_out === 1'b1) done_seen++;
        end
        total++; if (steps_seen !== 0 || busy_seen !== 0 || done_seen !== 0) begin
            bad++; $display("FAIL zero_steps_quiet: got step=%0d busy=%0d done=%0d cycles want 0", steps_seen, busy_seen, done_seen);
        end
    endtask

    task automatic test_abort();
        int r, t, act;
        logic prev;
        start_move(10, 1'b0, 100, 100, 0);
        r = 0; t = 0; prev = 1'b0;
        while (r < 3 && t < 2000) begin
            @(negedge clk_in); t++;
            if (step_out === 1'b1 && prev !== 1'b1) r++;
            prev = step_out;
        end
        total++; if (r !== 3) begin
            bad++; $display("FAIL abort_wait: got %0d rises want 3", r);
        end
        repeat (5) @(negedge clk_in);
        total++; if (step_out !== 1'b1) begin
            bad++; $display("FAIL abort_pre_high: got %b want 1", step_out);
        end
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        total++; if (step_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            bad++; $display("FAIL abort_outputs: got step=%b busy=%b done=%b want 0 0 0", step_out, busy_out, done_out);
        end
        total++; if (steps_left_out !== 32'd7) begin
            bad++; $display("FAIL abort_steps_left: got %0d want 7", steps_left_out);
        end
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (step_out === 1'b1 || busy_out === 1'b1 || done_out === 1'b1) act++;
        end
        total++; if (act !== 0 || steps_left_out !== 32'd7) begin
            bad++; $display("FAIL abort_quiet: got active=%0d steps_left=%0d want 0 and 7", act, steps_left_out);
        end
        start_move(1, 1'b1, 60, 60, 0);
        total++; if (busy_out !== 1'b1 || steps_left_out !== 32'd1) begin
            bad++; $display("FAIL abort_restart: got busy=%b steps_left=%0d want 1 and 1", busy_out, steps_left_out);
        end
        measure(200, -1);
        total++; if (done_t !== PW + 60 || rises.size() !== 1) begin
            bad++; $display("FAIL abort_restart_done: got done=%0d rises=%0d want %0d and 1", done_t, rises.size(), PW + 60);
        end
    endtask

    task automatic test_clamp_ignore();
        start_move(3, 1'b1, 10, 10, 5);
        measure(400, 60);
        total++; if (rises.size() !== 3) begin
            bad++; $display("FAIL clamp_count: got %0d want 3", rises.size());
        end
        for (int i = 0; i < 3 && i < rises.size(); i++) begin
            total++; if (rises[i] !== PW + 50 * i) begin
                bad++; $display("FAIL clamp_rise%0d: got %0d want %0d", i, rises[i], PW + 50 * i);
            end
        end
        total++; if (done_t !== PW + 150 || dir_out !== 1'b1 || steps_left_out !== 32'd0) begin
            bad++; $display("FAIL clamp_ignore_end: got done=%0d dir=%b left=%0d want %0d 1 0", done_t, dir_out, steps_left_out, PW + 150);
        end
    endtask

    task automatic test_reset_mid_move();
        int t, act;
        start_move(5, 1'b1, 200, 200, 0);
        t = 0;
        while (step_out !== 1'b1 && t < 500) begin @(negedge clk_in); t++; end
        total++; if (step_out !== 1'b1) begin
            bad++; $display("FAIL reset_mid_wait: got step=%b want 1", step_out);
        end
        #5 reset_in = 1'b1;
        #1;
        total++; if (step_out !== 1'b0 || busy_out !== 1'b0 || dir_out !== 1'b0 || done_out !== 1'b0 || steps_left_out !== 32'd0) begin
            bad++; $display("FAIL reset_mid_outputs: got step=%b busy=%b dir=%b done=%b left=%0d want all 0", step_out, busy_out, dir_out, done_out, steps_left_out);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (step_out === 1'b1 || busy_out === 1'b1 || done_out === 1'b1) act++;
        end
        total++; if (act !== 0) begin
            bad++; $display("FAIL reset_no_resume: got %0d active cycles want 0", act);
        end
        reset_in = 1'b1;
        @(negedge clk_in);
        steps_in = 32'd2; dir_in = 1'b0; period_start_in = 24'd80; period_min_in = 24'd80; accel_in = 24'd0;
        reset_in = 1'b0; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        total++; if (busy_out !== 1'b1 || steps_left_out !== 32'd2) begin
            bad++; $display("FAIL reset_first_start: got busy=%b left=%0d want 1 and 2", busy_out, steps_left_out);
        end
        measure(300, -1);
        total++; if (done_t !== PW + 160 || rises.size() !== 2) begin
            bad++; $display("FAIL reset_first_move: got done=%0d rises=%0d want %0d and 2", done_t, rises.size(), PW + 160);
        end
    endtask

    initial begin
        test_reset();
        test_profile();
        test_zero_steps();
        test_abort();
        test_clamp_ignore();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
